// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-organised memory that responds to CPU load, store and fetch
//            requests over a req/ack handshake with a fixed, configurable
//            latency. Misaligned or out-of-range accesses complete with err=1.
//            A faulted store is not written. A faulted load returns zero.
// Ports    : clk       - rising-edge clock
//            reset     - synchronous, active-high reset
//            req       - request valid (sampled only while ready=1)
//            we        - 1=store, 0=load/fetch (sampled with req)
//            addr      - byte address
//            wdata     - store data
//            ready     - idle and able to accept a request
//            ack       - one-cycle completion pulse
//            rdata     - load data (valid with ack, held until next response)
//            err       - completion with fault (valid only with ack)
//            rd_count  - completed good loads, saturating
//            wr_count  - completed good stores, saturating
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 4096,  // power of two
  parameter int LATENCY     = 2      // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         C_AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Storage. It is left untouched by reset so that preloaded contents survive.
  logic [31:0] mem [0:DEPTH_WORDS-1];

  state_t            r_state;
  logic              r_ready;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [15:0]       r_rd_count;
  logic [15:0]       r_wr_count;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_fault;
  logic [C_AW-1:0]   r_word;
  logic [31:0]       r_wdata;

  logic [C_AW-1:0]   w_word;
  logic              w_fault;
  logic              w_commit;

  // Decode of the request presented this cycle. Everything later uses the
  // copies latched at acceptance, so the initiator may change the bus freely.
  assign w_word  = addr[C_AW+1:2];
  assign w_fault = (addr[1:0] != 2'b00) || ((addr >> (C_AW + 2)) != 32'd0);

  // A store commits at the edge that ends RESP. A reset on that same edge
  // aborts the transaction, so the write is suppressed.
  assign w_commit = (r_state == ST_RESP) && r_we && !r_fault && !reset;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      mem[r_word] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_fault    <= 1'b0;
      r_word     <= '0;
      r_wdata    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // ready stays low for the first edge after reset. Requests are
          // only taken once ready has actually been shown to the initiator.
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (req) begin
            r_ready <= 1'b0;
            r_we    <= we;
            r_word  <= w_word;
            r_wdata <= wdata;
            r_fault <= w_fault;
            r_cnt   <= C_LAT_M1;
            if (LATENCY == 1) begin
              // No wait phase, so respond straight from the live request.
              r_state <= ST_RESP;
              r_ack   <= 1'b1;
              r_err   <= w_fault;
              if (!we) begin
                r_rdata <= w_fault ? 32'd0 : mem[w_word];
              end
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            r_err   <= r_fault;
            if (!r_we) begin
              r_rdata <= r_fault ? 32'd0 : mem[r_word];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          if (!r_fault) begin
            if (r_we) begin
              if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end else begin
              if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign ack      = r_ack;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. It uses one instance with
//            LATENCY=2 (a) and one with LATENCY=1 (b). Expected responses are
//            queued when a request is driven. They are compared when ack is
//            seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req_a, we_a, ready_a, ack_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [15:0] rdc_a, wrc_a;

  logic        req_b, we_b, ready_b, ack_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [15:0] rdc_b, wrc_b;

  mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .ready(ready_a), .ack(ack_a), .rdata(rdata_a),
    .err(err_a), .rd_count(rdc_a), .wr_count(wrc_a)
  );

  mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .ready(ready_b), .ack(ack_b), .rdata(rdata_b),
    .err(err_b), .rd_count(rdc_b), .wr_count(wrc_b)
  );

  typedef struct {
    logic        is_load;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic f_ready(input int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic f_ack(input int d);
    return (d == 0) ? ack_a : ack_b;
  endfunction

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      req_a = r; we_a = w; addr_a = a; wdata_a = wd;
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = wd;
    end
  endtask

  // One complete transaction. Call at a negedge with the DUT idle. It returns
  // at the negedge after the response cycle, with ready checked.
  task automatic run_txn(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] exp_rd, input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (!f_ready(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_value("ready_before_req", {31'd0, f_ready(d)}, 32'd1);
    e.is_load = !w;
    e.err     = exp_err;
    e.rdata   = exp_rd;
    if (d == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
    drive(d, 1'b1, w, a, wd);
    @(negedge clk);
    // Scramble the bus after acceptance. Only the latched copy may matter.
    drive(d, 1'b0, w, $urandom, $urandom);
    n = 1;
    while (!f_ack(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_value("ack_latency", n, lat);
    @(negedge clk);
    check_value("ready_after_resp", {31'd0, f_ready(d)}, 32'd1);
  endtask

  task automatic score(input int d, input logic ack_got, input logic e_got,
                       input logic [31:0] rd_got);
    exp_t e;
    if ((d == 0 && sb_a.size() == 0) || (d == 1 && sb_b.size() == 0)) begin
      check_value("unexpected_ack", {31'd0, ack_got}, 32'd0);
      return;
    end
    if (d == 0) e = sb_a.pop_front();
    else        e = sb_b.pop_front();
    check_value("err", {31'd0, e_got}, {31'd0, e.err});
    if (e.is_load) check_value("rdata", rd_got, e.rdata);
  endtask

  always @(negedge clk) begin
    if (ack_a) score(0, ack_a, err_a, rdata_a);
    if (ack_b) score(1, ack_b, err_b, rdata_b);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, first_k, last_k;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    @(negedge clk);
    check_value("rst_ready", {31'd0, ready_a}, 32'd0);
    check_value("rst_ack",   {31'd0, ack_a},   32'd0);
    check_value("rst_err",   {31'd0, err_a},   32'd0);
    check_value("rst_rdata", rdata_a, 32'd0);
    check_value("rst_rdc",   {16'd0, rdc_a}, 32'd0);
    check_value("rst_wrc",   {16'd0, wrc_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_value("post_rst_ready", {31'd0, ready_a}, 32'd1);
    check_value("post_rst_ack",   {31'd0, ack_a},   32'd0);

    // Store/load round trip, LATENCY=2
    run_txn(0, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0, 32'd0, 2);
    run_txn(0, 1'b0, 32'h2000, 32'd0,        1'b0, 32'hDEADBEEF, 2);
    check_value("rt_wrc", {16'd0, wrc_a}, 32'd1);
    check_value("rt_rdc", {16'd0, rdc_a}, 32'd1);

    // Instruction word at address 0, fetched with LATENCY=1
    run_txn(1, 1'b1, 32'h0, 32'h20080005, 1'b0, 32'd0, 1);
    run_txn(1, 1'b0, 32'h0, 32'd0,        1'b0, 32'h20080005, 1);
    // Read-after-write: load accepted on the edge right after the store's RESP
    run_txn(1, 1'b1, 32'h2004, 32'hA5A5A5A5, 1'b0, 32'd0, 1);
    run_txn(1, 1'b0, 32'h2004, 32'd0,        1'b0, 32'hA5A5A5A5, 1);
    check_value("b_rdc", {16'd0, rdc_b}, 32'd2);
    check_value("b_wrc", {16'd0, wrc_b}, 32'd2);

    // Faults: misaligned store, then an out-of-range load
    run_txn(0, 1'b1, 32'h2002, 32'h11111111, 1'b1, 32'd0, 2);
    run_txn(0, 1'b0, 32'h2000, 32'd0,        1'b0, 32'hDEADBEEF, 2);
    run_txn(0, 1'b0, 32'h4000, 32'd0,        1'b1, 32'd0, 2);
    check_value("fault_rdc", {16'd0, rdc_a}, 32'd2);
    check_value("fault_wrc", {16'd0, wrc_a}, 32'd1);

    // Prior contents for the abort case
    run_txn(0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 32'd0, 2);

    // Busy: req held for 9 edges gives accepts at edges 1, 4 and 7.
    for (int i = 0; i < 3; i++) sb_a.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    drive(0, 1'b1, 1'b0, 32'h2000, 32'd0);
    acks = 0; first_k = 0; last_k = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (ack_a) begin
        acks++;
        if (first_k == 0) first_k = k;
        last_k = k;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_value("busy_acks",    acks,    3);
    check_value("busy_first",   first_k, 2);
    check_value("busy_last",    last_k,  8);
    check_value("busy_rdc", {16'd0, rdc_a}, 32'd5);
    @(negedge clk);

    // Saturation: preset the load counter near the top
    force u_dut_a.r_rd_count = 16'hFFFE;
    @(negedge clk);
    release u_dut_a.r_rd_count;
    @(negedge clk);
    check_value("sat_preset", {16'd0, rdc_a}, 32'h0000FFFE);
    run_txn(0, 1'b0, 32'h2000, 32'd0, 1'b0, 32'hDEADBEEF, 2);
    check_value("sat_top", {16'd0, rdc_a}, 32'h0000FFFF);
    run_txn(0, 1'b0, 32'h2000, 32'd0, 1'b0, 32'hDEADBEEF, 2);
    check_value("sat_hold", {16'd0, rdc_a}, 32'h0000FFFF);
    check_value("sat_wrc",  {16'd0, wrc_a}, 32'd2);

    // Abort a store in WAIT. req stays high during reset and must be dropped.
    drive(0, 1'b1, 1'b1, 32'h10, 32'h12345678);
    @(negedge clk);
    check_value("abort_busy", {31'd0, ready_a}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_value("abort_ack",   {31'd0, ack_a},   32'd0);
    check_value("abort_ready", {31'd0, ready_a}, 32'd0);
    check_value("abort_wrc",   {16'd0, wrc_a},   32'd0);
    check_value("abort_rdc",   {16'd0, rdc_a},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_value("abort_ready_again", {31'd0, ready_a}, 32'd1);
    run_txn(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hCAFEF00D, 2);
    check_value("abort_rdc_after", {16'd0, rdc_a}, 32'd1);
    check_value("abort_wrc_after", {16'd0, wrc_a}, 32'd0);

    repeat (3) @(negedge clk);
    check_value("sb_a_drained", sb_a.size(), 0);
    check_value("sb_b_drained", sb_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
